// File: rtl/guess_ctrl_pkg.sv
// Shared definitions for the xAyB guess-number game controller and its display driver.
package guess_ctrl_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned ENTRY_W    = DIGIT_W * NUM_DIGITS;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned TRY_W      = 4;
  localparam int unsigned BLINK_W    = 16;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    Q_ENTRY = 2'd0,
    A_ENTRY = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } game_state_e;

endpackage

// File: rtl/guess_ctrl_ab_scorer.sv
// Combinational xAyB scorer: A = same digit same place, B = same digit other place.
module guess_ctrl_ab_scorer
  import guess_ctrl_pkg::*;
(
  input  logic [ENTRY_W-1:0] secret,
  input  logic [ENTRY_W-1:0] guess,
  output logic [CNT_W-1:0]   a,
  output logic [CNT_W-1:0]   b
);

  logic [3:0] a_sum;
  logic [3:0] b_sum;

  always_comb begin
    a_sum = '0;
    b_sum = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (guess[i*DIGIT_W +: DIGIT_W] == secret[j*DIGIT_W +: DIGIT_W]) begin
          if (i == j) a_sum = a_sum + 4'd1;
          else        b_sum = b_sum + 4'd1;
        end
      end
    end
    // Entry rejects repeated digits, so B never exceeds 4 in play; clamp guards odd inputs.
    a = 3'(a_sum);
    b = (b_sum > 4'd4) ? 3'd4 : 3'(b_sum);
  end

endmodule

// File: rtl/guess_ctrl.sv
// Guess-number game controller: digit entry, secret storage, scoring, blink and try counting.
module guess_ctrl
  import guess_ctrl_pkg::*;
#(
  parameter logic [BLINK_W-1:0] BLINK_HALF = 16'd250,
  parameter logic [TRY_W-1:0]   MAX_TRIES  = 4'd10
) (
  input  logic                clk_div,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [DIGIT_W-1:0]  key_code,
  input  logic                key_clear,
  input  logic                key_enter,
  output logic [IDX_W-1:0]    digit_state,
  output logic                qa_state,
  output logic                match,
  output logic                show,
  output logic [CNT_W-1:0]    r_a,
  output logic [CNT_W-1:0]    r_b,
  output logic [TRY_W-1:0]    attempts,
  output logic [ENTRY_W-1:0]  entry_digits
);

  game_state_e         state_q, state_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [ENTRY_W-1:0]  secret_q, secret_d;
  logic [CNT_W-1:0]    score_a_q, score_a_d;
  logic [CNT_W-1:0]    score_b_q, score_b_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_on_q, blink_on_d;

  logic [IDX_W-1:0]    digit_state_q, digit_state_d;
  logic                qa_state_q, qa_state_d;
  logic                match_q, match_d;
  logic                show_q, show_d;
  logic [CNT_W-1:0]    r_a_q, r_a_d;
  logic [CNT_W-1:0]    r_b_q, r_b_d;
  logic [TRY_W-1:0]    attempts_q, attempts_d;
  logic [ENTRY_W-1:0]  entry_digits_q, entry_digits_d;

  logic [CNT_W-1:0]    scorer_a;
  logic [CNT_W-1:0]    scorer_b;
  logic                dup;
  logic                accept;

  guess_ctrl_ab_scorer u_scorer (
    .secret (secret_q),
    .guess  (entry_q),
    .a      (scorer_a),
    .b      (scorer_b)
  );

  // Next-state and next-output logic; outputs mirror the game state one cycle later.
  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    entry_d     = entry_q;
    secret_d    = secret_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    tries_d     = tries_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    dup = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((2'(j) < digit_idx_q) && (entry_q[j*DIGIT_W +: DIGIT_W] == key_code)) dup = 1'b1;
    end
    accept = key_valid && (key_code <= DIGIT_MAX) && !dup;

    case (state_q)
      Q_ENTRY, A_ENTRY: begin
        if (key_clear) begin
          entry_d     = '0;
          digit_idx_d = '0;
        end else if (accept) begin
          for (int j = 0; j < NUM_DIGITS; j++) begin
            if (2'(j) == digit_idx_q) entry_d[j*DIGIT_W +: DIGIT_W] = key_code;
          end
          digit_idx_d = digit_idx_q + 2'd1;
          if (digit_idx_q == 2'(NUM_DIGITS - 1)) begin
            if (state_q == Q_ENTRY) begin
              secret_d = entry_d;
              entry_d  = '0;
              state_d  = A_ENTRY;
            end else begin
              state_d  = COMPARE;
            end
          end
        end
      end
      COMPARE: begin
        score_a_d   = scorer_a;
        score_b_d   = scorer_b;
        tries_d     = (tries_q == MAX_TRIES) ? tries_q : tries_q + 4'd1;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (key_enter) begin
          entry_d     = '0;
          digit_idx_d = '0;
          if ((score_a_q == 3'd4) || (tries_q == MAX_TRIES)) begin
            state_d  = Q_ENTRY;
            tries_d  = '0;
            secret_d = '0;
          end else begin
            state_d  = A_ENTRY;
          end
        end else if (blink_cnt_q == BLINK_HALF - 16'd1) begin
          blink_cnt_d = '0;
          blink_on_d  = !blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
      end
      default: state_d = Q_ENTRY;
    endcase

    digit_state_d  = digit_idx_q;
    qa_state_d     = (state_q != Q_ENTRY);
    match_d        = (state_q == RESULT);
    show_d         = (state_q == RESULT) && blink_on_q;
    r_a_d          = score_a_q;
    r_b_d          = score_b_q;
    attempts_d     = tries_q;
    entry_digits_d = entry_q;
  end

  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      state_q        <= Q_ENTRY;
      digit_idx_q    <= '0;
      entry_q        <= '0;
      secret_q       <= '0;
      score_a_q      <= '0;
      score_b_q      <= '0;
      tries_q        <= '0;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b0;
      digit_state_q  <= '0;
      qa_state_q     <= 1'b0;
      match_q        <= 1'b0;
      show_q         <= 1'b0;
      r_a_q          <= '0;
      r_b_q          <= '0;
      attempts_q     <= '0;
      entry_digits_q <= '0;
    end else begin
      state_q        <= state_d;
      digit_idx_q    <= digit_idx_d;
      entry_q        <= entry_d;
      secret_q       <= secret_d;
      score_a_q      <= score_a_d;
      score_b_q      <= score_b_d;
      tries_q        <= tries_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      digit_state_q  <= digit_state_d;
      qa_state_q     <= qa_state_d;
      match_q        <= match_d;
      show_q         <= show_d;
      r_a_q          <= r_a_d;
      r_b_q          <= r_b_d;
      attempts_q     <= attempts_d;
      entry_digits_q <= entry_digits_d;
    end
  end

  assign digit_state  = digit_state_q;
  assign qa_state     = qa_state_q;
  assign match        = match_q;
  assign show         = show_q;
  assign r_a          = r_a_q;
  assign r_b          = r_b_q;
  assign attempts     = attempts_q;
  assign entry_digits = entry_digits_q;

endmodule

// File: tb/tb_guess_ctrl.sv
// Directed bench for guess_ctrl: vector table for game play, hand sequences for blink and reset.
module tb_guess_ctrl;

  logic        clk_div = 1'b0;
  logic        reset   = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code  = 4'd0;
  logic        key_clear = 1'b0;
  logic        key_enter = 1'b0;
  logic [1:0]  digit_state;
  logic        qa_state;
  logic        match;
  logic        show;
  logic [2:0]  r_a;
  logic [2:0]  r_b;
  logic [3:0]  attempts;
  logic [15:0] entry_digits;

  int n_tests = 0;
  int n_fail  = 0;

  guess_ctrl #(.BLINK_HALF(16'd4), .MAX_TRIES(4'd2)) dut (
    .clk_div      (clk_div),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_clear    (key_clear),
    .key_enter    (key_enter),
    .digit_state  (digit_state),
    .qa_state     (qa_state),
    .match        (match),
    .show         (show),
    .r_a          (r_a),
    .r_b          (r_b),
    .attempts     (attempts),
    .entry_digits (entry_digits)
  );

  always #5 clk_div = ~clk_div;

  typedef struct packed {
    logic        kv;
    logic [3:0]  kc;
    logic        clr;
    logic        ent;
    logic [1:0]  ds;
    logic        qa;
    logic        mt;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [3:0]  att;
    logic [15:0] digits;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic clr,
                              input logic ent, input logic [1:0] ds, input logic qa,
                              input logic mt, input logic [2:0] ra, input logic [2:0] rb,
                              input logic [3:0] att, input logic [15:0] digits);
    vec_t v;
    v.kv = kv; v.kc = kc; v.clr = clr; v.ent = ent;
    v.ds = ds; v.qa = qa; v.mt = mt; v.ra = ra; v.rb = rb; v.att = att; v.digits = digits;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_div);
  endtask

  // Hold inputs for one active edge, then release.
  task automatic pulse(input logic kv, input logic [3:0] kc, input logic clr, input logic ent);
    key_valid = kv; key_code = kc; key_clear = clr; key_enter = ent;
    tick();
    key_valid = 1'b0; key_code = 4'd0; key_clear = 1'b0; key_enter = 1'b0;
  endtask

  // One input cycle plus one idle cycle so the registered outputs reflect it.
  task automatic step(input logic kv, input logic [3:0] kc, input logic clr, input logic ent);
    pulse(kv, kc, clr, ent);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ds"},  16'(digit_state), 16'h0);
    check({tag, ".qa"},  16'(qa_state), 16'h0);
    check({tag, ".mt"},  16'(match), 16'h0);
    check({tag, ".sh"},  16'(show), 16'h0);
    check({tag, ".ra"},  16'(r_a), 16'h0);
    check({tag, ".rb"},  16'(r_b), 16'h0);
    check({tag, ".att"}, 16'(attempts), 16'h0);
    check({tag, ".ent"}, entry_digits, 16'h0);
  endtask

  initial begin
    // Q phase: duplicates, out-of-range code, clear beating a same-cycle key.
    vecs.push_back(mk(1, 4'd5,  0, 0, 2'd1, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0005));
    vecs.push_back(mk(1, 4'd5,  0, 0, 2'd1, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0005));
    vecs.push_back(mk(1, 4'd12, 0, 0, 2'd1, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0005));
    vecs.push_back(mk(1, 4'd6,  0, 0, 2'd2, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0065));
    vecs.push_back(mk(1, 4'd7,  0, 0, 2'd3, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0765));
    vecs.push_back(mk(1, 4'd8,  1, 0, 2'd0, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0000));
    // Game 1: secret 1234, winning guess 1234.
    vecs.push_back(mk(1, 4'd1,  0, 0, 2'd1, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0001));
    vecs.push_back(mk(1, 4'd2,  0, 0, 2'd2, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0021));
    vecs.push_back(mk(1, 4'd3,  0, 0, 2'd3, 0, 0, 3'd0, 3'd0, 4'd0, 16'h0321));
    vecs.push_back(mk(1, 4'd4,  0, 0, 2'd0, 1, 0, 3'd0, 3'd0, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 4'd0,  0, 1, 2'd0, 1, 0, 3'd0, 3'd0, 4'd0, 16'h0000));
    vecs.push_back(mk(1, 4'd1,  0, 0, 2'd1, 1, 0, 3'd0, 3'd0, 4'd0, 16'h0001));
    vecs.push_back(mk(1, 4'd2,  0, 0, 2'd2, 1, 0, 3'd0, 3'd0, 4'd0, 16'h0021));
    vecs.push_back(mk(1, 4'd3,  0, 0, 2'd3, 1, 0, 3'd0, 3'd0, 4'd0, 16'h0321));
    vecs.push_back(mk(1, 4'd4,  0, 0, 2'd0, 1, 0, 3'd0, 3'd0, 4'd0, 16'h4321));
    vecs.push_back(mk(0, 4'd0,  0, 0, 2'd0, 1, 1, 3'd4, 3'd0, 4'd1, 16'h4321));
    vecs.push_back(mk(1, 4'd9,  0, 0, 2'd0, 1, 1, 3'd4, 3'd0, 4'd1, 16'h4321));
    vecs.push_back(mk(0, 4'd0,  1, 0, 2'd0, 1, 1, 3'd4, 3'd0, 4'd1, 16'h4321));
    vecs.push_back(mk(0, 4'd0,  0, 1, 2'd0, 0, 0, 3'd4, 3'd0, 4'd0, 16'h0000));
    // Game 2: secret 1234, guesses 4321 then 1325 exhaust MAX_TRIES=2.
    vecs.push_back(mk(1, 4'd1,  0, 0, 2'd1, 0, 0, 3'd4, 3'd0, 4'd0, 16'h0001));
    vecs.push_back(mk(1, 4'd2,  0, 0, 2'd2, 0, 0, 3'd4, 3'd0, 4'd0, 16'h0021));
    vecs.push_back(mk(1, 4'd3,  0, 0, 2'd3, 0, 0, 3'd4, 3'd0, 4'd0, 16'h0321));
    vecs.push_back(mk(1, 4'd4,  0, 0, 2'd0, 1, 0, 3'd4, 3'd0, 4'd0, 16'h0000));
    vecs.push_back(mk(1, 4'd4,  0, 0, 2'd1, 1, 0, 3'd4, 3'd0, 4'd0, 16'h0004));
    vecs.push_back(mk(1, 4'd3,  0, 0, 2'd2, 1, 0, 3'd4, 3'd0, 4'd0, 16'h0034));
    vecs.push_back(mk(1, 4'd2,  0, 0, 2'd3, 1, 0, 3'd4, 3'd0, 4'd0, 16'h0234));
    vecs.push_back(mk(1, 4'd1,  0, 0, 2'd0, 1, 0, 3'd4, 3'd0, 4'd0, 16'h1234));
    vecs.push_back(mk(0, 4'd0,  0, 0, 2'd0, 1, 1, 3'd0, 3'd4, 4'd1, 16'h1234));
    vecs.push_back(mk(0, 4'd0,  0, 1, 2'd0, 1, 0, 3'd0, 3'd4, 4'd1, 16'h0000));
    vecs.push_back(mk(1, 4'd1,  0, 0, 2'd1, 1, 0, 3'd0, 3'd4, 4'd1, 16'h0001));
    vecs.push_back(mk(1, 4'd3,  0, 0, 2'd2, 1, 0, 3'd0, 3'd4, 4'd1, 16'h0031));
    vecs.push_back(mk(1, 4'd2,  0, 0, 2'd3, 1, 0, 3'd0, 3'd4, 4'd1, 16'h0231));
    vecs.push_back(mk(1, 4'd5,  0, 0, 2'd0, 1, 0, 3'd0, 3'd4, 4'd1, 16'h5231));
    vecs.push_back(mk(0, 4'd0,  0, 0, 2'd0, 1, 1, 3'd1, 3'd2, 4'd2, 16'h5231));
    vecs.push_back(mk(0, 4'd0,  0, 1, 2'd0, 0, 0, 3'd1, 3'd2, 4'd0, 16'h0000));

    reset = 1'b0;
    repeat (2) tick();
    check_zero("rst");
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].kc, vecs[i].clr, vecs[i].ent);
      check($sformatf("v%0d.ds", i),  16'(digit_state), 16'(vecs[i].ds));
      check($sformatf("v%0d.qa", i),  16'(qa_state),    16'(vecs[i].qa));
      check($sformatf("v%0d.mt", i),  16'(match),       16'(vecs[i].mt));
      check($sformatf("v%0d.ra", i),  16'(r_a),         16'(vecs[i].ra));
      check($sformatf("v%0d.rb", i),  16'(r_b),         16'(vecs[i].rb));
      check($sformatf("v%0d.att", i), 16'(attempts),    16'(vecs[i].att));
      check($sformatf("v%0d.ent", i), entry_digits,     vecs[i].digits);
    end

    // Blink: secret 1234, guess 5678; show pattern 1,1,1,1,0,0,0,0,1 from RESULT entry.
    step(1, 4'd1, 0, 0); step(1, 4'd2, 0, 0); step(1, 4'd3, 0, 0); step(1, 4'd4, 0, 0);
    step(1, 4'd5, 0, 0); step(1, 4'd6, 0, 0); step(1, 4'd7, 0, 0);
    pulse(1, 4'd8, 0, 0);
    tick();
    check("lat.match", 16'(match), 16'h0);
    check("lat.show",  16'(show),  16'h0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("blink%0d", k), 16'(show), ((k < 4) || (k == 8)) ? 16'h1 : 16'h0);
      check($sformatf("blink%0d.mt", k), 16'(match), 16'h1);
    end
    check("blink.ra",  16'(r_a), 16'h0);
    check("blink.rb",  16'(r_b), 16'h0);
    check("blink.att", 16'(attempts), 16'h1);

    step(0, 4'd0, 0, 1);
    check("miss.qa",  16'(qa_state), 16'h1);
    check("miss.ds",  16'(digit_state), 16'h0);
    check("miss.mt",  16'(match), 16'h0);
    check("miss.sh",  16'(show), 16'h0);
    check("miss.att", 16'(attempts), 16'h1);
    step(1, 4'd9, 0, 0);
    check("a9.ds",  16'(digit_state), 16'h1);
    check("a9.ent", entry_digits, 16'h0009);

    // Reset mid A_ENTRY drops the whole game.
    reset = 1'b0;
    tick();
    check_zero("midrst");
    reset = 1'b1;
    tick();
    step(1, 4'd1, 0, 0);
    check("post.qa",  16'(qa_state), 16'h0);
    check("post.ds",  16'(digit_state), 16'h1);
    check("post.ent", entry_digits, 16'h0001);
    check("post.att", 16'(attempts), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
